// File: rtl/heap_pkg.sv
// Shared parameters, derived widths and state encoding for the heap move sequencer.
package heap_pkg;

  localparam int unsigned MemoryElementWidth = 12;
  localparam int unsigned NArea              = 10;
  localparam int unsigned NArrays            = 20;
  localparam int unsigned NHeap              = 200;

  localparam int unsigned MEW = MemoryElementWidth;
  localparam int unsigned AW  = $clog2(NArrays);
  localparam int unsigned OW  = $clog2(NArea);
  localparam int unsigned HW  = $clog2(NHeap);
  // Length field width (0..NArea) and bound-check width (offset + length).
  localparam int unsigned LW  = OW + 1;
  localparam int unsigned EW  = OW + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    RDATA = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } move_state_t;

endpackage

// File: rtl/heap_address_gen.sv
// Flat heap address of one element: array * NArea + offset.
module heap_address_gen
  import heap_pkg::*;
(
  input  logic [AW-1:0] array_i,
  input  logic [OW-1:0] offset_i,
  output logic [HW-1:0] addr_o
);

  assign addr_o = HW'(array_i) * HW'(NArea) + HW'(offset_i);

endmodule

// File: rtl/heap_move_sequencer.sv
// memmove-style copier: one read then one write per element through the
// heap arbiter, with bounds checking and overlap-safe copy direction.
module heap_move_sequencer
  import heap_pkg::*;
(
  input  logic           clock,
  input  logic           resetN,
  input  logic           cmdValid,
  output logic           cmdReady,
  input  logic [AW-1:0]  cmdSource,
  input  logic [OW-1:0]  cmdSourceOff,
  input  logic [AW-1:0]  cmdTarget,
  input  logic [OW-1:0]  cmdTargetOff,
  input  logic [LW-1:0]  cmdLength,
  output logic           heapReq,
  input  logic           heapGnt,
  output logic           heapWe,
  output logic [HW-1:0]  heapAddr,
  output logic [MEW-1:0] heapWData,
  input  logic [MEW-1:0] heapRData,
  output logic           busy,
  output logic           done,
  output logic           error
);

  move_state_t    state_q, state_d;
  logic [AW-1:0]  src_q, src_d, tgt_q, tgt_d;
  logic [OW-1:0]  src_off_q, src_off_d, tgt_off_q, tgt_off_d;
  logic [LW-1:0]  len_q, len_d;
  logic [OW-1:0]  idx_q, idx_d;
  logic           desc_q, desc_d;
  logic [MEW-1:0] data_q, data_d;

  logic           ready_q, ready_d, busy_q, busy_d;
  logic           req_q, req_d, we_q, we_d;
  logic [HW-1:0]  addr_q, addr_d;
  logic           done_q, done_d, error_q, error_d;

  logic [EW-1:0]  src_end_s, tgt_end_s;
  logic           range_err_s, last_s;
  logic [AW-1:0]  gen_array_s;
  logic [OW-1:0]  gen_off_s;
  logic [HW-1:0]  gen_addr_s;

  // End-of-range sums are widened so offset+length cannot wrap.
  assign src_end_s   = EW'(src_off_q) + EW'(len_q);
  assign tgt_end_s   = EW'(tgt_off_q) + EW'(len_q);
  assign range_err_s = (src_q >= AW'(NArrays)) || (tgt_q >= AW'(NArrays)) ||
                       (src_end_s > EW'(NArea)) || (tgt_end_s > EW'(NArea));
  assign last_s      = desc_q ? (idx_q == {OW{1'b0}})
                              : (LW'(idx_q) == (len_q - LW'(1)));

  // Next state and datapath: latch command, check it, then walk the elements.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    src_off_d = src_off_q;
    tgt_d     = tgt_q;
    tgt_off_d = tgt_off_q;
    len_d     = len_q;
    idx_d     = idx_q;
    desc_d    = desc_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (cmdValid) begin
          src_d     = cmdSource;
          src_off_d = cmdSourceOff;
          tgt_d     = cmdTarget;
          tgt_off_d = cmdTargetOff;
          len_d     = cmdLength;
          state_d   = CHECK;
        end else begin
          state_d   = IDLE;
        end
      end
      CHECK: begin
        if (range_err_s) begin
          state_d = ERROR;
        end else if (len_q == {LW{1'b0}}) begin
          state_d = DONE;
        end else begin
          // Copy high-to-low only when the target overlaps above the source.
          desc_d  = (src_q == tgt_q) && (src_off_q < tgt_off_q);
          idx_d   = desc_d ? OW'(len_q - LW'(1)) : {OW{1'b0}};
          state_d = READ;
        end
      end
      READ: begin
        if (heapGnt) state_d = RDATA;
        else         state_d = READ;
      end
      RDATA: begin
        data_d  = heapRData;
        state_d = WRITE;
      end
      WRITE: begin
        if (heapGnt) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            idx_d   = desc_q ? (idx_q - OW'(1)) : (idx_q + OW'(1));
            state_d = READ;
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address generator operand select: source side for reads, target otherwise.
  always_comb begin
    if (state_d == READ) begin
      gen_array_s = src_d;
      gen_off_s   = src_off_d + idx_d;
    end else begin
      gen_array_s = tgt_d;
      gen_off_s   = tgt_off_d + idx_d;
    end
  end

  heap_address_gen u_addr_gen (
    .array_i  (gen_array_s),
    .offset_i (gen_off_s),
    .addr_o   (gen_addr_s)
  );

  // Output values for the state being entered, so every output is a flop.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b1;
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = {HW{1'b0}};
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      READ: begin
        req_d  = 1'b1;
        addr_d = gen_addr_s;
      end
      WRITE: begin
        req_d  = 1'b1;
        we_d   = 1'b1;
        addr_d = gen_addr_s;
      end
      DONE:    done_d  = 1'b1;
      ERROR:   error_d = 1'b1;
      default: busy_d  = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      src_q     <= {AW{1'b0}};
      src_off_q <= {OW{1'b0}};
      tgt_q     <= {AW{1'b0}};
      tgt_off_q <= {OW{1'b0}};
      len_q     <= {LW{1'b0}};
      idx_q     <= {OW{1'b0}};
      desc_q    <= 1'b0;
      data_q    <= {MEW{1'b0}};
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      src_off_q <= src_off_d;
      tgt_q     <= tgt_d;
      tgt_off_q <= tgt_off_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      desc_q    <= desc_d;
      data_q    <= data_d;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {HW{1'b0}};
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign cmdReady  = ready_q;
  assign busy      = busy_q;
  assign heapReq   = req_q;
  assign heapWe    = we_q;
  assign heapAddr  = addr_q;
  assign heapWData = data_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_heap_move_sequencer.sv
// Bench for heap_move_sequencer: heap memory model, expected-access scoreboard
// derived from memmove rules, and directed move commands.
module tb_heap_move_sequencer;
  import heap_pkg::*;

  logic           clock = 1'b0;
  logic           resetN = 1'b0;
  logic           cmdValid = 1'b0;
  logic           cmdReady;
  logic [AW-1:0]  cmdSource = '0;
  logic [OW-1:0]  cmdSourceOff = '0;
  logic [AW-1:0]  cmdTarget = '0;
  logic [OW-1:0]  cmdTargetOff = '0;
  logic [LW-1:0]  cmdLength = '0;
  logic           heapReq;
  logic           heapGnt = 1'b1;
  logic           heapWe;
  logic [HW-1:0]  heapAddr;
  logic [MEW-1:0] heapWData;
  logic [MEW-1:0] heapRData;
  logic           busy, done, error;

  heap_move_sequencer dut (
    .clock(clock), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdSource(cmdSource), .cmdSourceOff(cmdSourceOff), .cmdTarget(cmdTarget),
    .cmdTargetOff(cmdTargetOff), .cmdLength(cmdLength), .heapReq(heapReq),
    .heapGnt(heapGnt), .heapWe(heapWe), .heapAddr(heapAddr), .heapWData(heapWData),
    .heapRData(heapRData), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {bit we; int addr; int data;} acc_t;

  acc_t           exp_q[$];
  int             wr_log[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  int             req_cnt = 0;
  int             wr_cnt = 0;
  bit             hold_pend = 1'b0;
  int             hold_addr = 0;
  bit             hold_we = 1'b0;
  logic [MEW-1:0] mem [NHeap];
  int             ref_mem [NHeap];
  logic           init_req = 1'b0;

  function automatic int init_val(input int i);
    if (i < 10)      return i;
    else if (i < 20) return 100 + i - 10;
    else             return 1000 + i;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Single-port heap: granted access happens at the edge, read data next cycle.
  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < NHeap; i++) mem[i] <= MEW'(init_val(i));
    end else if (resetN && heapReq && heapGnt) begin
      if (heapWe) mem[heapAddr] <= heapWData;
      else        heapRData <= mem[heapAddr];
    end
  end

  // Per-cycle compare: handshake invariants, request hold, access scoreboard.
  always @(negedge clock) begin : cmp_proc
    acc_t a;
    if (!resetN) begin
      exp_q.delete();
      hold_pend <= 1'b0;
    end else begin
      check("ready_vs_busy", int'(cmdReady), int'(!busy));
      if (hold_pend) begin
        check("hold_req", int'(heapReq), 1);
        check("hold_addr", int'(heapAddr), hold_addr);
        check("hold_we", int'(heapWe), int'(hold_we));
      end
      if (heapReq) req_cnt <= req_cnt + 1;
      if (heapReq && heapGnt) begin
        hold_pend <= 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_access", int'(heapAddr), -1);
        end else begin
          a = exp_q.pop_front();
          check("acc_we", int'(heapWe), int'(a.we));
          check("acc_addr", int'(heapAddr), a.addr);
          if (a.we) check("acc_wdata", int'(heapWData), a.data);
        end
        if (heapWe) begin
          wr_cnt <= wr_cnt + 1;
          wr_log.push_back(int'(heapAddr));
        end
      end else begin
        hold_pend <= heapReq;
        hold_addr <= int'(heapAddr);
        hold_we   <= heapWe;
      end
    end
  end

  task automatic init_heap();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    for (int i = 0; i < NHeap; i++) ref_mem[i] = init_val(i);
  endtask

  // Model: rejection rule and issue order of accesses for one command.
  task automatic expect_move(input int src, so, tgt, to, len, output bit bad);
    bit desc;
    int k;
    bad = (src >= NArrays) || (tgt >= NArrays) || (so + len > NArea) || (to + len > NArea);
    exp_q.delete();
    if (!bad) begin
      desc = (src == tgt) && (so < to);
      for (int j = 0; j < len; j++) begin
        k = desc ? len - 1 - j : j;
        exp_q.push_back('{we: 1'b0, addr: src*NArea + so + k, data: 0});
        exp_q.push_back('{we: 1'b1, addr: tgt*NArea + to + k, data: ref_mem[src*NArea + so + k]});
      end
    end
  endtask

  // Model: heap after the first 'limit' writes of a command, in issue order.
  task automatic apply_ref(input int src, so, tgt, to, len, limit);
    int pre [NHeap];
    bit desc;
    int k;
    pre  = ref_mem;
    desc = (src == tgt) && (so < to);
    for (int j = 0; j < limit; j++) begin
      k = desc ? len - 1 - j : j;
      ref_mem[tgt*NArea + to + k] = pre[src*NArea + so + k];
    end
  endtask

  task automatic check_heap(input string name);
    int nbad = 0;
    for (int i = 0; i < NHeap; i++) if (int'(mem[i]) != ref_mem[i]) nbad++;
    check({name, "_heap_diffs"}, nbad, 0);
  endtask

  task automatic check_arr(input string name, input int base, input int e[10]);
    for (int i = 0; i < 10; i++) check($sformatf("%s[%0d]", name, i), int'(mem[base + i]), e[i]);
  endtask

  task automatic run_cmd(input int src, so, tgt, to, len, stall,
                         output int n_end, output int waits, output bit gd, output bit ge);
    int stall_left;
    stall_left   = stall;
    heapGnt      = (stall > 0) ? 1'b0 : 1'b1;
    cmdSource    = AW'(src);
    cmdSourceOff = OW'(so);
    cmdTarget    = AW'(tgt);
    cmdTargetOff = OW'(to);
    cmdLength    = LW'(len);
    cmdValid     = 1'b1;
    waits = 0;
    while (!cmdReady && waits < 20) begin
      step();
      waits++;
    end
    step();
    cmdValid = 1'b0;
    n_end = -1;
    gd = 1'b0;
    ge = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (stall_left == 0) heapGnt = 1'b1;
      else if (heapReq)    stall_left--;
      if (done || error) begin
        gd = done;
        ge = error;
        n_end = n;
        break;
      end
    end
    heapGnt = 1'b1;
  endtask

  task automatic do_move(input string name, input int src, so, tgt, to, len, stall,
                         input int exp_k, input bit exp_err, output int waits);
    bit bad, gd, ge;
    int n_end, req0;
    req0 = req_cnt;
    expect_move(src, so, tgt, to, len, bad);
    check({name, "_reject_rule"}, int'(bad), int'(exp_err));
    run_cmd(src, so, tgt, to, len, stall, n_end, waits, gd, ge);
    check({name, "_latency"}, n_end + 1, exp_k);
    check({name, "_done"}, int'(gd), int'(!exp_err));
    check({name, "_error"}, int'(ge), int'(exp_err));
    if (exp_err || len == 0) check({name, "_no_req"}, req_cnt - req0, 0);
    if (!bad) apply_ref(src, so, tgt, to, len, len);
    check_heap(name);
    check({name, "_acc_left"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int waits, w0, wc0, n;
    bit bad;

    // Reset state.
    step();
    step();
    check("rst_cmdReady", int'(cmdReady), 1);
    check("rst_heapReq", int'(heapReq), 0);
    check("rst_heapWe", int'(heapWe), 0);
    check("rst_heapAddr", int'(heapAddr), 0);
    check("rst_heapWData", int'(heapWData), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    resetN = 1'b1;
    step();

    // Forward move into another array.
    init_heap();
    do_move("fwd", 0, 4, 1, 2, 3, 0, 11, 1'b0, waits);
    check_arr("fwd_a1", 10, '{100, 101, 4, 5, 6, 105, 106, 107, 108, 109});
    check_arr("fwd_a0", 0, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});

    // Overlapping move upwards in the same array: must copy descending.
    init_heap();
    w0 = wr_log.size();
    do_move("ovl", 0, 0, 0, 2, 5, 0, 17, 1'b0, waits);
    check_arr("ovl_a0", 0, '{0, 1, 0, 1, 2, 3, 4, 7, 8, 9});
    check("ovl_first_waddr", (wr_log.size() > w0) ? wr_log[w0] : -1, 6);

    // Bounds errors.
    init_heap();
    do_move("bnd_off", 0, 0, 1, 8, 3, 0, 2, 1'b1, waits);
    do_move("bnd_src", 20, 0, 1, 0, 1, 0, 2, 1'b1, waits);

    // Grant stalls on the first read.
    init_heap();
    do_move("stall", 0, 4, 1, 2, 3, 3, 14, 1'b0, waits);
    check_arr("stall_a1", 10, '{100, 101, 4, 5, 6, 105, 106, 107, 108, 109});

    // Overlap downwards (ascending), full length, highest array index.
    init_heap();
    do_move("ovl_asc", 0, 5, 0, 1, 4, 0, 14, 1'b0, waits);
    check_arr("ovl_asc_a0", 0, '{0, 5, 6, 7, 8, 5, 6, 7, 8, 9});
    do_move("full", 2, 0, 3, 0, 10, 0, 32, 1'b0, waits);
    do_move("edge", 19, 0, 18, 7, 3, 0, 11, 1'b0, waits);

    // Zero length, then a back-to-back command.
    init_heap();
    do_move("zero", 0, 3, 1, 3, 0, 0, 2, 1'b0, waits);
    do_move("b2b", 0, 1, 1, 0, 2, 0, 8, 1'b0, waits);
    check("b2b_wait_cycles", waits, 1);
    check_arr("b2b_a1", 10, '{1, 2, 102, 103, 104, 105, 106, 107, 108, 109});

    // Reset after the second granted write.
    init_heap();
    expect_move(0, 3, 1, 0, 5, bad);
    wc0 = wr_cnt;
    cmdSource    = AW'(0);
    cmdSourceOff = OW'(3);
    cmdTarget    = AW'(1);
    cmdTargetOff = OW'(0);
    cmdLength    = LW'(5);
    cmdValid     = 1'b1;
    step();
    cmdValid = 1'b0;
    n = 0;
    while (wr_cnt < wc0 + 2 && n < 100) begin
      step();
      n++;
    end
    check("rst_mid_writes", wr_cnt - wc0, 2);
    resetN = 1'b0;
    #1;
    check("rst_mid_ready", int'(cmdReady), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_req", int'(heapReq), 0);
    check("rst_mid_addr", int'(heapAddr), 0);
    step();
    step();
    resetN = 1'b1;
    step();
    step();
    check("post_rst_ready", int'(cmdReady), 1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_req", int'(heapReq), 0);
    check("post_rst_done", int'(done), 0);
    apply_ref(0, 3, 1, 0, 5, 2);
    check_heap("rst_mid");
    check_arr("rst_mid_a1", 10, '{3, 4, 102, 103, 104, 105, 106, 107, 108, 109});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
